cam_reg_init_seq: RTL and testbench
===================================

# cam_reg_init_seq

Camera register initialisation sequencer; sits directly upstream of `i2c_controller` and drives its request port. On `start` it walks a register table held in an external synchronous ROM. It issues one single-byte SCCB/I2C register write per table entry, honours inline millisecond delay entries and retries NACKed writes. It reports `done` or `error` to the top-level camera bring-up logic for OV7670/OV2640.

## Interface
- `CAM_ADDR`, 7'h21: 7-bit device address driven on `ADDR` (OV7670; 7'h30 for OV2640).
- `ROM_AW`, 8: table address width; table holds up to 2^ROM_AW entries.
- `TICKS_PER_MS`, 50000: `clk` cycles per millisecond of delay entries.
- `MAX_RETRY`, 3: write attempts per entry before the block declares an error (at least 1).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; begins a pass in IDLE, DONE or ERROR.
- `busy`  out  1  high from the start accept until DONE/ERROR.
- `done`  out  1  high in DONE until the next start.
- `error`  out  1  high in ERROR until the next start.
- `err_index`  out  ROM_AW  table index of the failing entry; valid while `error`.
- `rom_addr`  out  ROM_AW  table read address, registered.
- `rom_data`  in  16  `{reg[15:8], data[7:0]}`; valid 1 cycle after `rom_addr` changes.
- `m_valid`  out  1  request to the controller.
- `m_we`  out  1  always 0, the controller's register-write encoding.
- `ADDR`  out  7  equals `CAM_ADDR`.
- `REG`  out  8  register index.
- `DATA_IN`  out  8  register value.
- `DataNum`  out  5  always 0, single data byte.
- `m_ready`  in  1  one-cycle completion pulse from the controller.
- `NACK`  in  1  valid in the `m_ready` cycle; 1 means the transfer was not acknowledged.

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, DELAY, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + `start`=1 -> FETCH. On this transition:
  - `rom_addr`=0, retry count=0.
  - `done`/`error` clear, `busy`=1.
- FETCH: wait one cycle for ROM latency, then go to DECODE.
- DECODE: registers `rom_data` and selects the entry type.
  - 16'hFFFF is the end marker -> DONE.
  - `reg`=8'hFF is a delay entry -> DELAY, loading `data` ms. If `data`=0 -> NEXT directly.
  - Anything else is a write entry -> ISSUE, setting `REG`=reg and `DATA_IN`=data.
- ISSUE:
  - `m_valid`=1 with `ADDR`/`REG`/`DATA_IN`/`m_we`/`DataNum` stable until `m_ready`.
  - On `m_ready` with `NACK`=0 -> NEXT.
  - On `m_ready` with `NACK`=1, retry count increments. If count < `MAX_RETRY`, re-issue after one cycle with `m_valid`=0. Otherwise -> ERROR with `err_index`=`rom_addr`.
- DELAY: counts `data`*`TICKS_PER_MS` cycles, then -> NEXT. The counter is wide enough for 255 ms at the parameter value.
- NEXT:
  - Clears the retry count.
  - If `rom_addr` = 2^ROM_AW-1 -> DONE; the address does not wrap.
  - Otherwise `rom_addr`+1 -> FETCH.
- DONE/ERROR: `busy`=0. `start` held high restarts immediately on the next cycle.
- `start` is ignored while `busy`.

## Timing
- Reset (async, `rst`=0) values:
  - State IDLE; `busy`/`done`/`error`/`m_valid`=0.
  - `rom_addr`=0, `err_index`=0, `REG`=0, `DATA_IN`=0.
  - `m_we`=0, `DataNum`=0, `ADDR`=`CAM_ADDR`.
- Reset mid-transfer drops `m_valid` immediately. The controller shares `rst`, so no bus recovery is attempted.
- `start` sampled high in IDLE at edge N gives `busy`=1 and `rom_addr`=0 at N+1, DECODE at N+2, and `m_valid`=1 at N+3 for a write entry.
- `m_valid` deasserts on the edge after the `m_ready` cycle. It is never high in the cycle following `m_ready`.
- Back-to-back write entries: `m_valid` is low for at least 3 cycles between requests (NEXT, FETCH, DECODE).
- A delay entry of k ms holds DELAY for exactly k*`TICKS_PER_MS` cycles.
- A `m_ready` pulse outside ISSUE is ignored.

## Test plan
- **Two writes then end.** Table {0x1280, 0x1101, 0xFFFF}, controller model acks after 20 cycles. Expect 2 requests, with (`REG`,`DATA_IN`) equal to (0x12,0x80) then (0x11,0x01), `ADDR`=0x21 and `m_we`=0. Then `done`=1, `busy`=0, `error`=0.
- **Delay entry.** Table {0xFF02, 0x1204, 0xFFFF}, `TICKS_PER_MS`=10. Expect the first `m_valid` exactly 20 cycles after DELAY entry, in addition to the fixed fetch overhead.
- **Persistent NACK.** Entry 1 always NACKs, `MAX_RETRY`=3. Expect 3 requests for 0x3A, then `error`=1 and `err_index`=1. Entry 2 is never requested.
- **Single NACK then ack.** Expect a second request with identical fields, then normal continuation and `done`=1.
- **Table without end marker.** `ROM_AW`=2, all 4 entries are writes. Expect 4 writes, `done`=1, and `rom_addr` stays at 3 (no wrap).
- **Reset mid-transfer.** Pull `rst` low while `m_valid`=1 in ISSUE. Expect `m_valid`=0 and `busy`=0 without a clock edge. After release and `start`, the sequence restarts from entry 0.

Source files
------------

// File: rtl/cam_reg_init_seq.sv
// Camera register initialisation sequencer: walks a register table in a synchronous ROM
// and issues one single-byte register write per entry, with inline ms delays and NACK retries.
module cam_reg_init_seq #(
  parameter logic [6:0] CAM_ADDR     = 7'h21,
  parameter int         ROM_AW       = 8,
  parameter int         TICKS_PER_MS = 50000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              m_valid,
  output logic              m_we,
  output logic [6:0]        ADDR,
  output logic [7:0]        REG,
  output logic [7:0]        DATA_IN,
  output logic [4:0]        DataNum,
  input  logic              m_ready,
  input  logic              NACK
);

  localparam int DLY_W = $clog2(255 * TICKS_PER_MS + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_DELAY  = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [ROM_AW-1:0]  err_index_q, err_index_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               m_valid_q, m_valid_d;
  logic [RTY_W-1:0]   retry_inc_s;
  logic               accept_s;
  logic               nack_s;

  assign retry_inc_s = retry_q + RTY_W'(1);
  assign accept_s    = ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR)) && start;
  assign nack_s      = (state_q == S_ISSUE) && m_valid_q && m_ready && NACK;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_FETCH;
        else       state_d = state_q;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (rom_data[15:8] == 8'hFF) begin
          if (rom_data[7:0] == 8'h00) state_d = S_NEXT;
          else                        state_d = S_DELAY;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_valid_q && m_ready) begin
          if (!NACK)                                   state_d = S_NEXT;
          else if (retry_inc_s < RTY_W'(MAX_RETRY))    state_d = S_ISSUE;
          else                                         state_d = S_ERROR;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DELAY: begin
        if (dly_cnt_q == '0) state_d = S_NEXT;
        else                 state_d = S_DELAY;
      end
      S_NEXT: begin
        if (rom_addr_q == '1) state_d = S_DONE;
        else                  state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    rom_addr_d  = rom_addr_q;
    retry_d     = retry_q;
    err_index_d = err_index_q;
    reg_d       = reg_q;
    data_d      = data_q;
    dly_cnt_d   = dly_cnt_q;
    if (accept_s) begin
      rom_addr_d = '0;
      retry_d    = '0;
    end else if (state_q == S_NEXT) begin
      retry_d = '0;
      if (state_d == S_FETCH) rom_addr_d = rom_addr_q + ROM_AW'(1);
      else                    rom_addr_d = rom_addr_q;
    end else if (nack_s) begin
      retry_d = retry_inc_s;
      if (state_d == S_ERROR) err_index_d = rom_addr_q;
      else                    err_index_d = err_index_q;
    end else begin
      rom_addr_d = rom_addr_q;
    end
    if ((state_q == S_DECODE) && (state_d == S_ISSUE)) begin
      reg_d  = rom_data[15:8];
      data_d = rom_data[7:0];
    end else begin
      reg_d  = reg_q;
      data_d = data_q;
    end
    // Loaded with k*TICKS-1 so DELAY is occupied for exactly k*TICKS cycles
    if ((state_q == S_DECODE) && (state_d == S_DELAY)) begin
      dly_cnt_d = DLY_W'(rom_data[7:0]) * DLY_W'(TICKS_PER_MS) - DLY_W'(1);
    end else if ((state_q == S_DELAY) && (dly_cnt_q != '0)) begin
      dly_cnt_d = dly_cnt_q - DLY_W'(1);
    end else begin
      dly_cnt_d = dly_cnt_q;
    end
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
    // A NACK leaves ISSUE with m_valid low for one cycle before the re-issue
    m_valid_d = (state_d == S_ISSUE) && !((state_q == S_ISSUE) && m_valid_q && m_ready);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_q  <= '0;
      retry_q     <= '0;
      err_index_q <= '0;
      reg_q       <= 8'h00;
      data_q      <= 8'h00;
      dly_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      retry_q     <= retry_d;
      err_index_q <= err_index_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      dly_cnt_q   <= dly_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign rom_addr  = rom_addr_q;
  assign m_valid   = m_valid_q;
  assign m_we      = 1'b0;
  assign ADDR      = CAM_ADDR;
  assign REG       = reg_q;
  assign DATA_IN   = data_q;
  assign DataNum   = 5'd0;

endmodule

// File: tb/tb_cam_reg_init_seq.sv
// Directed bench for cam_reg_init_seq with a synchronous ROM model and an I2C controller model.
module tb_cam_reg_init_seq;

  localparam int ROM_AW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, error;
  logic [ROM_AW-1:0] err_index, rom_addr;
  logic [15:0]       rom_data;
  logic              m_valid, m_we;
  logic [6:0]        ADDR;
  logic [7:0]        REG, DATA_IN;
  logic [4:0]        DataNum;
  logic              m_ready;
  logic              NACK;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rom [0:3];
  int          ack_lat;
  logic [7:0]  nack_reg;
  int          nack_limit;
  int          nack_base;
  int          nacks_given = 0;
  int          ctl_cnt = 0;
  int          req_n = 0;
  logic [7:0]  req_reg  [0:63];
  logic [7:0]  req_data [0:63];
  logic [6:0]  req_addr [0:63];
  logic        req_we   [0:63];
  logic [4:0]  req_num  [0:63];
  int          base;

  cam_reg_init_seq #(
    .CAM_ADDR(7'h21), .ROM_AW(ROM_AW), .TICKS_PER_MS(10), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_we(m_we), .ADDR(ADDR), .REG(REG), .DATA_IN(DATA_IN),
    .DataNum(DataNum), .m_ready(m_ready), .NACK(NACK)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: acks ack_lat cycles after m_valid, NACKs the chosen register nack_limit times
  always @(negedge clk) begin
    if (!rst) begin
      m_ready = 1'b0;
      NACK    = 1'b0;
      ctl_cnt = 0;
    end else if (m_ready) begin
      check("mvalid_after_ready", {31'd0, m_valid}, 32'd0);
      m_ready = 1'b0;
      NACK    = 1'b0;
      ctl_cnt = 0;
    end else if (m_valid) begin
      if (ctl_cnt >= ack_lat) begin
        m_ready = 1'b1;
        NACK    = (REG == nack_reg) && ((nacks_given - nack_base) < nack_limit);
        if (NACK) nacks_given++;
        if (req_n < 64) begin
          req_reg[req_n]  = REG;
          req_data[req_n] = DATA_IN;
          req_addr[req_n] = ADDR;
          req_we[req_n]   = m_we;
          req_num[req_n]  = DataNum;
        end
        req_n++;
        ctl_cnt = 0;
      end else begin
        ctl_cnt++;
      end
    end else begin
      ctl_cnt = 0;
    end
  end

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic setup(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3, input int lat, input logic [7:0] nreg, input int nlim);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    ack_lat    = lat;
    nack_reg   = nreg;
    nack_limit = nlim;
    nack_base  = nacks_given;
    base       = req_n;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    setup(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 20, 8'h00, 0);
    repeat (3) @(negedge clk);
    check("rst_flags", {28'd0, busy, done, error, m_valid}, 32'd0);
    check("rst_addr", {24'd0, rom_addr, err_index, 2'b00}, 32'd0);
    check("rst_regdata", {16'd0, REG, DATA_IN}, 32'd0);
    check("rst_const", {19'd0, ADDR, m_we, DataNum}, {19'd0, 7'h21, 1'b0, 5'd0});
    rst = 1'b1;
    @(negedge clk);

    // Two writes then end marker
    kick();
    check("t1_busy_addr", {29'd0, busy, rom_addr}, {29'd0, 1'b1, 2'd0});
    @(negedge clk);
    check("t1_decode_mvalid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check("t1_first_mvalid", {15'd0, m_valid, REG, DATA_IN}, {15'd0, 1'b1, 8'h12, 8'h80});
    wait_end(400);
    check("t1_reqs", req_n - base, 2);
    check("t1_req0", {req_addr[base], req_we[base], req_num[base], req_reg[base], req_data[base]},
          {7'h21, 1'b0, 5'd0, 8'h12, 8'h80});
    check("t1_req1", {req_addr[base+1], req_we[base+1], req_num[base+1], req_reg[base+1], req_data[base+1]},
          {7'h21, 1'b0, 5'd0, 8'h11, 8'h01});
    check("t1_end", {29'd0, done, busy, error}, {29'd0, 3'b100});

    // 2 ms delay entry at 10 ticks/ms
    setup(16'hFF02, 16'h1204, 16'hFFFF, 16'h0000, 4, 8'h00, 0);
    kick();
    check("t2_done_cleared", {30'd0, done, busy}, {30'd0, 2'b01});
    repeat (24) @(negedge clk);
    check("t2_mvalid_early", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check("t2_mvalid_on_time", {15'd0, m_valid, REG, DATA_IN}, {15'd0, 1'b1, 8'h12, 8'h04});
    wait_end(400);
    check("t2_end", {29'd0, done, busy, error}, {29'd0, 3'b100});
    check("t2_reqs", req_n - base, 1);

    // Persistent NACK on entry 1
    setup(16'h1280, 16'h3A55, 16'h1301, 16'hFFFF, 3, 8'h3A, 1000);
    kick();
    wait_end(400);
    check("t3_flags", {29'd0, done, busy, error}, {29'd0, 3'b001});
    check("t3_err_index", {30'd0, err_index}, 32'd1);
    check("t3_reqs", req_n - base, 4);
    check("t3_retries", {8'd0, req_reg[base+1], req_reg[base+2], req_reg[base+3]}, {8'd0, 8'h3A, 8'h3A, 8'h3A});

    // Single NACK then ack, restarting straight from ERROR
    setup(16'h3A55, 16'h1301, 16'hFFFF, 16'h0000, 3, 8'h3A, 1);
    kick();
    check("t4_error_cleared", {30'd0, error, busy}, {30'd0, 2'b01});
    wait_end(400);
    check("t4_flags", {29'd0, done, busy, error}, {29'd0, 3'b100});
    check("t4_reqs", req_n - base, 3);
    check("t4_retry_same", {req_reg[base+1], req_data[base+1], req_reg[base], req_data[base]},
          {8'h3A, 8'h55, 8'h3A, 8'h55});
    check("t4_continue", {16'd0, req_reg[base+2], req_data[base+2]}, {16'd0, 8'h13, 8'h01});

    // Full table without end marker
    setup(16'h1001, 16'h1102, 16'h1203, 16'h1304, 2, 8'h00, 0);
    kick();
    wait_end(400);
    check("t5_flags", {29'd0, done, busy, error}, {29'd0, 3'b100});
    check("t5_reqs", req_n - base, 4);
    check("t5_last", {16'd0, req_reg[base+3], req_data[base+3]}, {16'd0, 8'h13, 8'h04});
    repeat (3) @(negedge clk);
    check("t5_no_wrap", {30'd0, rom_addr}, 32'd3);

    // Reset in the middle of an outstanding request
    setup(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 50, 8'h00, 0);
    kick();
    repeat (2) @(negedge clk);
    check("t6_mvalid_up", {31'd0, m_valid}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_async_drop", {30'd0, m_valid, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    setup(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 5, 8'h00, 0);
    kick();
    check("t6_restart_addr", {29'd0, busy, rom_addr}, {29'd0, 1'b1, 2'd0});
    @(negedge clk);
    @(negedge clk);
    check("t6_restart_entry0", {15'd0, m_valid, REG, DATA_IN}, {15'd0, 1'b1, 8'h12, 8'h80});
    wait_end(400);
    check("t6_reqs", req_n - base, 2);
    check("t6_end", {29'd0, done, busy, error}, {29'd0, 3'b100});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
